// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, head-flit field layout and arbiter states.
package noc_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned DEST_W   = 4;
  localparam int unsigned LEN_LSB  = 4;
  localparam int unsigned LEN_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // A zero length field still carries the head flit, so it means one flit.
  function automatic logic [LEN_W-1:0] head_len(input logic [LEN_W-1:0] field);
    return (field == '0) ? LEN_W'(1) : field;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first set req bit after index 'last', with wrap.
module noc_rr_pick #(
  parameter int N  = 5,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  // Two passes: indices above 'last' first, then wrap around to 0..last.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!vld && req[i] && (i > int'(last))) begin
        gnt[i] = 1'b1;
        vld    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!vld && req[i] && (i <= int'(last))) begin
        gnt[i] = 1'b1;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_packet_arbiter.sv
// Wormhole output-link arbiter: round-robin grant held from head flit to tail flit.
// Define NOC_ARB_VARLEN_EN to take packet length from head flit bits [7:4].
module noc_packet_arbiter #(
  parameter int N_IN       = 5,
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int PKT_LEN    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]            in_valid,
  output logic [N_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_IN-1:0]            grant,
  output logic                       busy
);
  import noc_pkg::*;

  localparam int LW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t           state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    gidx;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_eff;
  logic [N_IN-1:0]  pick_gnt;
  logic             pick_vld;
  logic             xfer;
  logic             tail;

  noc_rr_pick #(
    .N  (N_IN),
    .LW (LW)
  ) u_pick (
    .req  (in_valid),
    .last (last),
    .gnt  (pick_gnt),
    .vld  (pick_vld)
  );

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (grant[i]) gidx = LW'(i);
    end
  end

  always_comb begin
    in_ready  = '0;
    out_data  = '0;
    out_valid = 1'b0;
    if (state == LOCK) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (grant[i]) begin
          out_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
          out_valid   = in_valid[i];
          in_ready[i] = out_ready;
        end
      end
    end
  end

  assign xfer = (state == LOCK) && out_valid && out_ready;
  assign tail = xfer && (count == len_eff - LEN_W'(1));
  assign busy = (state == LOCK);

`ifdef NOC_ARB_VARLEN_EN
  logic [LEN_W-1:0] len_q;

  // The head transfer decides its own fate from the live field; later flits use the latch.
  assign len_eff = (count == '0) ? head_len(out_data[LEN_LSB +: LEN_W]) : len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '1;
    end else if (state == IDLE) begin
      len_q <= '1;
    end else if (xfer && (count == '0)) begin
      len_q <= head_len(out_data[LEN_LSB +: LEN_W]);
    end
  end
`else
  assign len_eff = LEN_W'(PKT_LEN);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      count <= '0;
      last  <= LW'(N_IN - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_gnt;
            count <= '0;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
            if (tail) begin
              state <= IDLE;
              grant <= '0;
              count <= '0;
              last  <= gidx;
            end else begin
              count <= count + LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// Directed self-checking bench for noc_packet_arbiter (default build or NOC_ARB_VARLEN_EN).
module tb_noc_packet_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int PL = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            busy;

  int passes = 0;
  int total  = 0;

  noc_packet_arbiter #(
    .N_IN       (N),
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int p, input logic [31:0] v);
    in_data[p*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

`ifndef NOC_ARB_VARLEN_EN
  int ptr [N];
  int npk [N];

  task automatic drive_all();
    for (int p = 0; p < N; p++) begin
      in_valid[p] = (npk[p] > 0);
      set_flit(p, (32'(npk[p]) << 12) | (32'(p) << 8) | 32'(ptr[p]));
    end
  endtask
`endif

  initial begin
    int g;
    int k;
    int order [4];
    logic [7:0] pat;
    logic [8:0] vpat;

    rst       = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    set_flit(2, 32'hDEAD_0001);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    in_valid = '1;
    tick();
    chk("rst_hold_grant", grant, 0);
    in_valid = '0;
    rst = 1'b1;

`ifndef NOC_ARB_VARLEN_EN
    // Single requester on input 2.
    in_valid = 5'b00100;
    set_flit(2, 32'hA000_0001);
    #1;
    chk("s_idle_valid", out_valid, 0);
    chk("s_idle_ready", in_ready, 0);
    tick();
    chk("s_grant", grant, 5'b00100);
    chk("s_busy", busy, 1);
    for (int f = 1; f <= PL; f++) begin
      set_flit(2, 32'hA000_0000 + 32'(f));
      #1;
      chk("s_data", out_data, 32'hA000_0000 + 32'(f));
      chk("s_valid", out_valid, 1);
      chk("s_ready", in_ready, 5'b00100);
      tick();
    end
    in_valid = '0;
    #1;
    chk("s_end_busy", busy, 0);
    chk("s_end_grant", grant, 0);
    chk("s_end_valid", out_valid, 0);

    // Contention: inputs 0,1,4 with input 0 holding two packets.
    do_reset();
    for (int p = 0; p < N; p++) begin
      ptr[p] = 1;
      npk[p] = 0;
    end
    npk[0] = 2;
    npk[1] = 1;
    npk[4] = 1;
    order = '{0, 1, 4, 0};
    for (int j = 0; j < 4; j++) begin
      g = order[j];
      drive_all();
      #1;
      chk("c_bubble_valid", out_valid, 0);
      chk("c_bubble_grant", grant, 0);
      tick();
      chk("c_grant", grant, 32'(1) << g);
      for (int f = 1; f <= PL; f++) begin
        drive_all();
        #1;
        chk("c_data", out_data, (32'(npk[g]) << 12) | (32'(g) << 8) | 32'(f));
        chk("c_ready", in_ready, 32'(1) << g);
        tick();
        ptr[g]++;
      end
      ptr[g] = 1;
      npk[g]--;
    end
    in_valid = '0;
    #1;
    chk("c_end_busy", busy, 0);

    // Backpressure mid-packet on input 2 while input 3 waits.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 5'b00100;
    set_flit(2, 32'hB000_0001);
    tick();
    chk("b_grant", grant, 5'b00100);
    in_valid = 5'b01100;
    pat = 8'b1111_0011;
    k = 1;
    for (int c = 0; c < 8; c++) begin
      out_ready = pat[c];
      set_flit(2, 32'hB000_0000 + 32'(k));
      #1;
      chk("b_data", out_data, 32'hB000_0000 + 32'(k));
      chk("b_ready", in_ready, pat[c] ? 32'h4 : 32'h0);
      chk("b_grant_hold", grant, 5'b00100);
      tick();
      if (pat[c]) k++;
    end
    out_ready = 1'b1;
    chk("b_end_busy", busy, 0);
    chk("b_end_grant", grant, 0);
    in_valid = '0;

    // Valid gap on input 3 while input 1 requests.
    do_reset();
    in_valid = 5'b01000;
    tick();
    chk("v_grant", grant, 5'b01000);
    in_valid = 5'b01010;
    vpat = 9'b1_1110_0011;
    k = 1;
    for (int c = 0; c < 9; c++) begin
      in_valid[3] = vpat[c];
      set_flit(3, 32'hD000_0000 + 32'(k));
      #1;
      chk("v_out_valid", out_valid, 32'(vpat[c]));
      chk("v_grant_hold", grant, 5'b01000);
      tick();
      if (vpat[c]) k++;
    end
    in_valid[3] = 1'b0;
    #1;
    chk("v_bubble_grant", grant, 0);
    tick();
    chk("v_next_grant", grant, 5'b00010);
    in_valid = '0;

    // Reset in the middle of a packet.
    do_reset();
    in_valid = 5'b01000;
    tick();
    chk("r_grant", grant, 5'b01000);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("r_async_grant", grant, 0);
    chk("r_async_busy", busy, 0);
    chk("r_async_valid", out_valid, 0);
    tick();
    in_valid = 5'b11001;
    rst = 1'b1;
    #1;
    chk("r_idle_grant", grant, 0);
    tick();
    chk("r_first_grant", grant, 5'b00001);
    in_valid = '0;
`else
    // Length from head field: 3 flits, then a zero field meaning one flit.
    out_ready = 1'b1;
    in_valid  = 5'b00010;
    set_flit(1, 32'h0000_0035);
    tick();
    chk("l_grant", grant, 5'b00010);
    #1;
    chk("l_head", out_data, 32'h0000_0035);
    tick();
    set_flit(1, 32'h0000_00F2);
    #1;
    chk("l_busy_mid", busy, 1);
    tick();
    set_flit(1, 32'h0000_00F3);
    #1;
    chk("l_tail_data", out_data, 32'h0000_00F3);
    tick();
    chk("l3_busy", busy, 0);
    chk("l3_grant", grant, 0);
    set_flit(1, 32'h0000_0005);
    tick();
    chk("l1_grant", grant, 5'b00010);
    #1;
    chk("l1_data", out_data, 32'h0000_0005);
    tick();
    in_valid = '0;
    #1;
    chk("l1_busy", busy, 0);
    chk("l1_grant_clr", grant, 0);
`endif

    tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
